main_multiplier: RTL and testbench

- Pipelined 16x16 unsigned multiplier producing a full 32-bit product.
- Sits in the arithmetic datapath and replaces a purely combinational multiply with a registered, fixed-latency unit.
- A valid strobe travels alongside each operand pair so that downstream logic knows when the product is usable.

---
 rtl/main_multiplier.sv | 153 +++++++++++++++
 tb/tb_main_multiplier.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/main_multiplier.sv
// -----------------------------------------------------------------------------
// main_multiplier
//
// Two-stage pipelined 16x16 multiplier with a full 32-bit product. Operands
// are split into 8-bit halves; stage 1 registers the four 8x8 partial
// products, stage 2 recombines them into the final product.
//
// Handshake: in_valid qualifies first_num/second_num on the rising edge it is
// sampled high. There is no backpressure: every qualified pair is accepted,
// and exactly LATENCY edges later out_valid is high for one cycle while
// solution carries that pair's product. solution holds its last value
// whenever no new result emerges.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous, active-high reset; clears all pipeline state
//   in_valid    qualifies first_num/second_num
//   first_num   16-bit multiplicand
//   second_num  16-bit multiplier
//   out_valid   one-cycle strobe marking a fresh product on solution
//   solution    32-bit product
//
// Build option:
//   MAIN_MULTIPLIER_SIGNED_EN  when defined, operands and product are two's
//                              complement; otherwise everything is unsigned.
// -----------------------------------------------------------------------------
module main_multiplier #(
  parameter int unsigned LATENCY = 2  // fixed; only 2 is legal
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] first_num,
  input  logic [15:0] second_num,
  output logic        out_valid,
  output logic [31:0] solution
);

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  logic [15:0] op_a;
  logic [15:0] op_b;

`ifdef MAIN_MULTIPLIER_SIGNED_EN
  logic sign_in;

  // Magnitudes: -0x8000 maps to 0x8000, which is still correct when read as
  // an unsigned 16-bit value, so no extra bit is needed.
  always_comb begin
    op_a    = first_num[15]  ? (~first_num  + 16'd1) : first_num;
    op_b    = second_num[15] ? (~second_num + 16'd1) : second_num;
    sign_in = first_num[15] ^ second_num[15];
  end
`else
  always_comb begin
    op_a = first_num;
    op_b = second_num;
  end
`endif

  logic [7:0] a_h;
  logic [7:0] a_l;
  logic [7:0] b_h;
  logic [7:0] b_l;

  always_comb begin
    a_h = op_a[15:8];
    a_l = op_a[7:0];
    b_h = op_b[15:8];
    b_l = op_b[7:0];
  end

  // ---------------------------------------------------------------------------
  // Valid pipeline: vpipe[0] is the stage-1 valid, vpipe[LATENCY-1] drives
  // out_valid. Shifts every cycle so a strobe never repeats.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] vpipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[LATENCY-2:0], in_valid};
    end
  end

  assign out_valid = vpipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Stage 1: partial products. Loaded only on a qualified pair so the stage
  // holds its contents while idle.
  // ---------------------------------------------------------------------------
  logic [15:0] pp_ll;
  logic [15:0] pp_lh;
  logic [15:0] pp_hl;
  logic [15:0] pp_hh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_ll <= '0;
      pp_lh <= '0;
      pp_hl <= '0;
      pp_hh <= '0;
    end else if (in_valid) begin
      pp_ll <= {8'd0, a_l} * {8'd0, b_l};
      pp_lh <= {8'd0, a_l} * {8'd0, b_h};
      pp_hl <= {8'd0, a_h} * {8'd0, b_l};
      pp_hh <= {8'd0, a_h} * {8'd0, b_h};
    end
  end

`ifdef MAIN_MULTIPLIER_SIGNED_EN
  logic sign_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_s1 <= 1'b0;
    end else if (in_valid) begin
      sign_s1 <= sign_in;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: recombination. The two cross terms can carry into bit 16, so
  // their sum is kept at 17 bits before being shifted into place.
  // ---------------------------------------------------------------------------
  logic [16:0] mid_sum;
  logic [31:0] prod_mag;
  logic [31:0] prod_final;

  always_comb begin
    mid_sum  = {1'b0, pp_lh} + {1'b0, pp_hl};
    prod_mag = {pp_hh, 16'd0} + {7'd0, mid_sum, 8'd0} + {16'd0, pp_ll};
`ifdef MAIN_MULTIPLIER_SIGNED_EN
    prod_final = sign_s1 ? (~prod_mag + 32'd1) : prod_mag;
`else
    prod_final = prod_mag;
`endif
  end

  // solution only updates when a valid pair reaches this stage, so stale
  // stage-1 contents never leak out while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      solution <= '0;
    end else if (vpipe[0]) begin
      solution <= prod_final;
    end
  end

endmodule

// File: tb/tb_main_multiplier.sv
module tb_main_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] first_num;
  logic [15:0] second_num;
  logic        out_valid;
  logic [31:0] solution;

  int n_tests;
  int n_fail;
  int cyc;

  logic [31:0] exp_q[$];
  int          due_q[$];

  main_multiplier #(.LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .first_num  (first_num),
    .second_num (second_num),
    .out_valid  (out_valid),
    .solution   (solution)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef MAIN_MULTIPLIER_SIGNED_EN
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] p;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    p  = sa * sb;
    return p;
`else
    logic [31:0] ua;
    logic [31:0] ub;
    ua = {16'd0, a};
    ub = {16'd0, b};
    return ua * ub;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    first_num  = a;
    second_num = b;
    exp_q.push_back(model(a, b));
    due_q.push_back(cyc + 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      first_num  = 16'($urandom_range(0, 65535));
      second_num = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("stray_out_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("solution", solution, e);
        check("latency", cyc, d);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] last;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    first_num  = '0;
    second_num = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_solution", solution, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Single operations with gaps
    send(16'd123, 16'd345); idle(3); drain();
    check("single_123x345", solution, 32'd42435);
    send(16'd154, 16'd654); idle(3); drain();
    check("single_154x654", solution, 32'd100716);
    send(16'd186, 16'd348); idle(3); drain();
    check("single_186x348", solution, 32'd64728);

    // Back-to-back: scoreboard checks order and per-result latency
    send(16'd123, 16'd345);
    send(16'd154, 16'd654);
    send(16'd186, 16'd348);
    idle(1); drain();

    // Boundaries
    send(16'hFFFF, 16'hFFFF);
    send(16'd0, 16'hFFFF);
    send(16'd1, 16'd40000);
    send(16'd256, 16'd256);
    idle(1); drain();
    check("last_256x256", solution, model(16'd256, 16'd256));

`ifdef MAIN_MULTIPLIER_SIGNED_EN
    send(16'hFFFE, 16'd3);
    send(16'h8000, 16'h8000);
    send(16'h8000, 16'd1);
    idle(1); drain();
    check("signed_last", solution, 32'hFFFF8000);
`endif

    // Hold: idle inputs must not disturb solution
    send(16'd1000, 16'd7);
    idle(1); drain();
    last = model(16'd1000, 16'd7);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      @(negedge clk);
      check("hold_solution", solution, last);
      check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic with random gaps
    for (int i = 0; i < 30; i++) begin
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1); drain();

    // Reset mid-operation with two pairs in flight
    send(16'd500, 16'd600);
    send(16'd700, 16'd800);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    check("async_rst_solution", solution, 32'd0);
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(6);
    @(negedge clk);
    check("post_rst_solution", solution, 32'd0);

    // Resume after reset
    send(16'd42, 16'd42); idle(2); drain();
    check("resume", solution, 32'd1764);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
